sipo_deframer: RTL and testbench

- Serial-to-parallel receive stage; the downstream counterpart of the team's parallel-in/serial-out shifter.
- Samples a qualified serial bit stream, aligns word boundaries using a start marker, and assembles DATA_WIDTH-bit words.
- Presents each word on a valid/ready parallel interface, with sticky overrun and alignment-error flags for the control/status register block.

---
 rtl/sipo_deframer_if.sv | 25 ++
 rtl/sipo_deframer.sv | 103 ++++++++++
 tb/tb_sipo_deframer.sv | 209 ++++++++++++++++++++
 3 files changed

// File: rtl/sipo_deframer_if.sv
// Parallel-side bundle of the serial deframer: bit stream in, word handshake
// and sticky status out.
interface sipo_deframer_if #(
    parameter int unsigned DATA_WIDTH = 8
);
    logic                  i_bit_valid;
    logic                  i_bit;
    logic                  i_start;
    logic [DATA_WIDTH-1:0] o_data;
    logic                  o_valid;
    logic                  i_ready;
    logic                  o_overrun;
    logic                  o_align_err;
    logic                  i_clr_flags;

    modport slave (
        input  i_bit_valid, i_bit, i_start, i_ready, i_clr_flags,
        output o_data, o_valid, o_overrun, o_align_err
    );

    modport master (
        output i_bit_valid, i_bit, i_start, i_ready, i_clr_flags,
        input  o_data, o_valid, o_overrun, o_align_err
    );
endinterface

// File: rtl/sipo_deframer.sv
// Serial-to-parallel receiver: frames words on a start marker, holds one word
// on a valid/ready output and reports sticky overrun and alignment errors.
module sipo_deframer #(
    parameter int unsigned DATA_WIDTH   = 8,
    parameter string       DO_MSB_FIRST = "true"
) (
    input logic            i_clk,
    input logic            i_a_rst,
    sipo_deframer_if.slave bus
);
    localparam bit          MsbFirst = (DO_MSB_FIRST == "true");
    localparam int unsigned CntW     = $clog2(DATA_WIDTH + 1);
    localparam logic [CntW-1:0] LastCnt = CntW'(DATA_WIDTH - 1);

    localparam logic StIdle  = 1'b0;
    localparam logic StShift = 1'b1;

    logic                  state_q, state_d;
    logic [CntW-1:0]       cnt_q, cnt_d;
    logic [DATA_WIDTH-1:0] shreg_q, shreg_d;
    logic [DATA_WIDTH-1:0] data_q, data_d;
    logic                  valid_q, valid_d;
    logic                  overrun_q, overrun_d;
    logic                  align_q, align_d;

    logic                  complete, align_set, overrun_set;
    logic [DATA_WIDTH-1:0] shifted, first_word;

    // A start bit is equivalent to shifting into a cleared register.
    assign shifted    = MsbFirst ? {shreg_q[DATA_WIDTH-2:0], bus.i_bit}
                                 : {bus.i_bit, shreg_q[DATA_WIDTH-1:1]};
    assign first_word = MsbFirst ? {{(DATA_WIDTH-1){1'b0}}, bus.i_bit}
                                 : {bus.i_bit, {(DATA_WIDTH-1){1'b0}}};

    always_comb begin
        state_d   = state_q;
        cnt_d     = cnt_q;
        shreg_d   = shreg_q;
        complete  = 1'b0;
        align_set = 1'b0;
        if (bus.i_bit_valid) begin
            if (bus.i_start) begin
                align_set = (state_q == StShift);
                shreg_d   = first_word;
                cnt_d     = CntW'(1);
                state_d   = StShift;
            end else if (state_q == StShift) begin
                shreg_d = shifted;
                if (cnt_q == LastCnt) begin
                    complete = 1'b1;
                    cnt_d    = '0;
                    state_d  = StIdle;
                end else begin
                    cnt_d = cnt_q + CntW'(1);
                end
            end
        end
    end

    always_comb begin
        data_d      = data_q;
        valid_d     = valid_q;
        overrun_set = 1'b0;
        if (complete) begin
            if (!valid_q || bus.i_ready) begin
                data_d  = shreg_d;
                valid_d = 1'b1;
            end else begin
                overrun_set = 1'b1;
            end
        end else if (valid_q && bus.i_ready) begin
            valid_d = 1'b0;
        end
        // Set beats clear when both happen in one cycle.
        overrun_d = overrun_set | (overrun_q & ~bus.i_clr_flags);
        align_d   = align_set | (align_q & ~bus.i_clr_flags);
    end

    always_ff @(posedge i_clk or posedge i_a_rst) begin
        if (i_a_rst) begin
            state_q   <= StIdle;
            cnt_q     <= '0;
            shreg_q   <= '0;
            data_q    <= '0;
            valid_q   <= 1'b0;
            overrun_q <= 1'b0;
            align_q   <= 1'b0;
        end else begin
            state_q   <= state_d;
            cnt_q     <= cnt_d;
            shreg_q   <= shreg_d;
            data_q    <= data_d;
            valid_q   <= valid_d;
            overrun_q <= overrun_d;
            align_q   <= align_d;
        end
    end

    assign bus.o_data      = data_q;
    assign bus.o_valid     = valid_q;
    assign bus.o_overrun   = overrun_q;
    assign bus.o_align_err = align_q;
endmodule

// File: tb/tb_sipo_deframer.sv
// Bench for sipo_deframer: MSB-first and LSB-first instances share one bit
// stream; expected words are queued as they are sent and checked on handshake.
module tb_sipo_deframer;
    logic clk = 1'b0;
    logic rst = 1'b1;
    int   n_checks = 0;
    int   n_errors = 0;

    logic [7:0] exp_m[$];
    logic [7:0] exp_l[$];

    sipo_deframer_if #(.DATA_WIDTH(8)) bus_m ();
    sipo_deframer_if #(.DATA_WIDTH(8)) bus_l ();

    assign bus_l.i_bit_valid = bus_m.i_bit_valid;
    assign bus_l.i_bit       = bus_m.i_bit;
    assign bus_l.i_start     = bus_m.i_start;
    assign bus_l.i_ready     = bus_m.i_ready;
    assign bus_l.i_clr_flags = bus_m.i_clr_flags;

    sipo_deframer #(.DATA_WIDTH(8), .DO_MSB_FIRST("true")) dut_msb (
        .i_clk   (clk),
        .i_a_rst (rst),
        .bus     (bus_m)
    );

    sipo_deframer #(.DATA_WIDTH(8), .DO_MSB_FIRST("false")) dut_lsb (
        .i_clk   (clk),
        .i_a_rst (rst),
        .bus     (bus_l)
    );

    always #5 clk = ~clk;

    task automatic check_val(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_checks++;
        if (obs !== exp) begin
            n_errors++;
            $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", tag, obs, exp, $time);
        end
    endtask

    function automatic logic [7:0] rev8(input logic [7:0] w);
        logic [7:0] r;
        for (int i = 0; i < 8; i++) r[i] = w[7-i];
        return r;
    endfunction

    task automatic expect_word(input logic [7:0] w);
        exp_m.push_back(w);
        exp_l.push_back(rev8(w));
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic send_bit(input logic b, input logic s);
        bus_m.i_bit_valid = 1'b1;
        bus_m.i_bit       = b;
        bus_m.i_start     = s;
        tick();
        bus_m.i_bit_valid = 1'b0;
        bus_m.i_start     = 1'b0;
    endtask

    // Serial order is w[7] first; ready can be raised for the completing edge.
    task automatic send_word(input logic [7:0] w, input int gap, input bit rdy_last);
        for (int i = 0; i < 8; i++) begin
            if (i > 0) repeat (gap) tick();
            if (i == 7 && rdy_last) bus_m.i_ready = 1'b1;
            send_bit(w[7-i], i == 0);
        end
    endtask

    // Scoreboard: every handshake must match the oldest queued word.
    always @(negedge clk) begin
        if (!rst) begin
            if (bus_m.o_valid && bus_m.i_ready) begin
                check_val("msb_word_queued", 32'(exp_m.size() != 0), 32'd1);
                if (exp_m.size() != 0) check_val("msb_word", 32'(bus_m.o_data), 32'(exp_m.pop_front()));
            end
            if (bus_l.o_valid && bus_l.i_ready) begin
                check_val("lsb_word_queued", 32'(exp_l.size() != 0), 32'd1);
                if (exp_l.size() != 0) check_val("lsb_word", 32'(bus_l.o_data), 32'(exp_l.pop_front()));
            end
        end
    end

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not finish");
        $fatal(1, "watchdog");
    end

    initial begin
        bus_m.i_bit_valid = 1'b0;
        bus_m.i_bit       = 1'b0;
        bus_m.i_start     = 1'b0;
        bus_m.i_ready     = 1'b0;
        bus_m.i_clr_flags = 1'b0;
        repeat (2) @(posedge clk);
        #1;
        check_val("rst_valid", 32'(bus_m.o_valid), 32'd0);
        check_val("rst_data", 32'(bus_m.o_data), 32'd0);
        check_val("rst_flags", 32'({bus_m.o_overrun, bus_m.o_align_err}), 32'd0);
        @(negedge clk);
        rst = 1'b0;
        tick();

        // One framed word, ready high, valid lasts one cycle.
        bus_m.i_ready = 1'b1;
        expect_word(8'hB4);
        send_word(8'hB4, 0, 1'b0);
        check_val("t1_valid_after_last", 32'(bus_m.o_valid), 32'd1);
        check_val("t1_data", 32'(bus_m.o_data), 32'hB4);
        check_val("t1_lsb_data", 32'(bus_l.o_data), 32'h2D);
        tick();
        check_val("t1_valid_one_cycle", 32'(bus_m.o_valid), 32'd0);

        // Same word with idle gaps between bits.
        expect_word(8'hB4);
        send_word(8'hB4, 3, 1'b0);
        check_val("t2_valid_after_last", 32'(bus_l.o_valid), 32'd1);
        check_val("t2_lsb_data", 32'(bus_l.o_data), 32'h2D);
        tick();
        check_val("t2_valid_one_cycle", 32'(bus_l.o_valid), 32'd0);

        // Back-to-back words with ready low: second word is dropped.
        bus_m.i_ready = 1'b0;
        expect_word(8'hB4);
        send_word(8'hB4, 0, 1'b0);
        send_word(8'h5A, 0, 1'b0);
        check_val("t3_valid", 32'(bus_m.o_valid), 32'd1);
        check_val("t3_data_held", 32'(bus_m.o_data), 32'hB4);
        check_val("t3_overrun", 32'(bus_m.o_overrun), 32'd1);
        check_val("t3_lsb_overrun", 32'(bus_l.o_overrun), 32'd1);
        bus_m.i_clr_flags = 1'b1;
        tick();
        bus_m.i_clr_flags = 1'b0;
        check_val("t3_overrun_clr", 32'(bus_m.o_overrun), 32'd0);
        bus_m.i_ready = 1'b1;
        tick();
        bus_m.i_ready = 1'b0;

        // Ready rises on the completing edge of the second word.
        expect_word(8'hB4);
        expect_word(8'h5A);
        send_word(8'hB4, 0, 1'b0);
        send_word(8'h5A, 0, 1'b1);
        check_val("t4_valid", 32'(bus_m.o_valid), 32'd1);
        check_val("t4_data", 32'(bus_m.o_data), 32'h5A);
        check_val("t4_overrun", 32'(bus_m.o_overrun), 32'd0);
        tick();

        // Start re-asserted on the fifth bit.
        send_bit(1'b1, 1'b1);
        send_bit(1'b0, 1'b0);
        send_bit(1'b1, 1'b0);
        send_bit(1'b1, 1'b0);
        expect_word(8'hC3);
        send_word(8'hC3, 0, 1'b0);
        check_val("t5_align_err", 32'(bus_m.o_align_err), 32'd1);
        check_val("t5_data", 32'(bus_m.o_data), 32'hC3);
        check_val("t5_lsb_align_err", 32'(bus_l.o_align_err), 32'd1);
        bus_m.i_clr_flags = 1'b1;
        tick();
        bus_m.i_clr_flags = 1'b0;
        check_val("t5_align_clr", 32'(bus_m.o_align_err), 32'd0);

        // Unframed bits are ignored.
        for (int i = 0; i < 10; i++) send_bit(1'($urandom_range(1)), 1'b0);
        tick();
        check_val("t6_no_valid", 32'(bus_m.o_valid), 32'd0);

        // Build up state, then reset asynchronously mid-word.
        bus_m.i_ready = 1'b0;
        send_word(8'hA5, 0, 1'b0);
        send_word(8'h11, 0, 1'b0);
        send_bit(1'b1, 1'b1);
        send_bit(1'b1, 1'b0);
        send_bit(1'b0, 1'b0);
        send_bit(1'b1, 1'b0);
        check_val("t6_pre_valid", 32'(bus_m.o_valid), 32'd1);
        check_val("t6_pre_overrun", 32'(bus_m.o_overrun), 32'd1);
        #3;
        rst = 1'b1;
        #1;
        check_val("t6_rst_valid", 32'(bus_m.o_valid), 32'd0);
        check_val("t6_rst_data", 32'(bus_m.o_data), 32'd0);
        check_val("t6_rst_flags", 32'({bus_m.o_overrun, bus_m.o_align_err}), 32'd0);
        @(negedge clk);
        rst = 1'b0;
        tick();
        bus_m.i_ready = 1'b1;
        expect_word(8'h96);
        send_word(8'h96, 0, 1'b0);
        check_val("t6_after_rst_data", 32'(bus_m.o_data), 32'h96);
        check_val("t6_after_rst_align", 32'(bus_m.o_align_err), 32'd0);
        tick();
        tick();

        check_val("msb_queue_drained", 32'(exp_m.size()), 32'd0);
        check_val("lsb_queue_drained", 32'(exp_l.size()), 32'd0);
        $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
        $finish;
    end
endmodule
